// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_sbox_pkg                                                             |
// | Shared AES S-box constants, byte type and GF(2^8) helper functions.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package aes_sbox_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t      AES_AFFINE_FWD = 8'h63;
    localparam byte_t      AES_AFFINE_INV = 8'h05;
    localparam logic [8:0] AES_GF_POLY    = 9'h11B;

    function automatic byte_t rotl8(input byte_t b, input logic [2:0] amt);
        byte_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[3'(3'(i) + amt)] = b[i];
        end
        return r;
    endfunction

    // Shift-and-add multiply; the 9-bit shift exposes the overflow bit for reduction.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b,
                                     input logic [8:0] poly = AES_GF_POLY);
        byte_t      p;
        byte_t      aa;
        logic [8:0] t;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            t = {aa, 1'b0};
            if (t[8]) t = t ^ poly;
            aa = t[7:0];
        end
        return p;
    endfunction

    function automatic byte_t inv_affine(input byte_t s, input byte_t c = AES_AFFINE_INV);
        return rotl8(s, 3'd1) ^ rotl8(s, 3'd3) ^ rotl8(s, 3'd6) ^ c;
    endfunction

    function automatic byte_t fwd_affine(input byte_t x);
        return x ^ rotl8(x, 3'd1) ^ rotl8(x, 3'd2) ^ rotl8(x, 3'd3) ^ rotl8(x, 3'd4)
               ^ AES_AFFINE_FWD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf256_inv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gf256_inv                                                                |
// | Combinational GF(2^8) inverse as x^254 (so 0 maps to 0).                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gf256_inv
    import aes_sbox_pkg::*;
#(
    parameter logic [8:0] POLY = AES_GF_POLY
) (
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);

    byte_t w_x2, w_x3, w_x6, w_x7, w_x14, w_x15, w_x30, w_x31;
    byte_t w_x62, w_x63, w_x126, w_x127, w_x254;

    // Exponent chain: alternate squaring and multiply-by-x to reach 2^8-2.
    assign w_x2   = gf_mul(a_i,    a_i,    POLY);
    assign w_x3   = gf_mul(w_x2,   a_i,    POLY);
    assign w_x6   = gf_mul(w_x3,   w_x3,   POLY);
    assign w_x7   = gf_mul(w_x6,   a_i,    POLY);
    assign w_x14  = gf_mul(w_x7,   w_x7,   POLY);
    assign w_x15  = gf_mul(w_x14,  a_i,    POLY);
    assign w_x30  = gf_mul(w_x15,  w_x15,  POLY);
    assign w_x31  = gf_mul(w_x30,  a_i,    POLY);
    assign w_x62  = gf_mul(w_x31,  w_x31,  POLY);
    assign w_x63  = gf_mul(w_x62,  a_i,    POLY);
    assign w_x126 = gf_mul(w_x63,  w_x63,  POLY);
    assign w_x127 = gf_mul(w_x126, a_i,    POLY);
    assign w_x254 = gf_mul(w_x127, w_x127, POLY);

    assign inv_o = w_x254;

endmodule
`default_nettype wire

// File: rtl/s_box_inverse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | s_box_inverse                                                            |
// | Pipelined AES inverse S-box with valid/ready handshakes on both sides.   |
// | Macro S_BOX_INVERSE_GF_INV_EN adds the GF(2^8) inversion stage.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module s_box_inverse
    import aes_sbox_pkg::*;
#(
    parameter logic [7:0] INV_AFFINE_CONSTANT = AES_AFFINE_INV,
    parameter logic [8:0] GF_POLY             = AES_GF_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready
);

    logic  v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    byte_t d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic  w_adv1, w_adv2, w_adv3;
    logic  w_s3_v;
    byte_t w_s3_d;

`ifdef S_BOX_INVERSE_GF_INV_EN
    logic  v2b_q, v2b_d, w_adv2b;
    byte_t d2b_q, d2b_d, w_inv;

    gf256_inv #(
        .POLY  (GF_POLY)
    ) u_gf256_inv (
        .a_i   (d2_q),
        .inv_o (w_inv)
    );

    assign w_adv2b = !v2b_q || w_adv3;
    assign w_adv2  = !v2_q  || w_adv2b;
    assign w_s3_v  = v2b_q;
    assign w_s3_d  = d2b_q;
`else
    logic w_unused_poly;
    assign w_unused_poly = ^GF_POLY;
    assign w_adv2 = !v2_q || w_adv3;
    assign w_s3_v = v2_q;
    assign w_s3_d = d2_q;
`endif

    // Ready chain: a stage may load whenever it is empty or its successor moves.
    assign w_adv3 = !v3_q || oready;
    assign w_adv1 = !v1_q || w_adv2;
    assign iready = w_adv1 && !rst;

    always_comb begin
        v1_d = v1_q;
        d1_d = d1_q;
        v2_d = v2_q;
        d2_d = d2_q;
        v3_d = v3_q;
        d3_d = d3_q;
        if (w_adv1) begin
            v1_d = ivalid;
            if (ivalid) d1_d = idata;
        end
        if (w_adv2) begin
            v2_d = v1_q;
            if (v1_q) d2_d = inv_affine(d1_q, INV_AFFINE_CONSTANT);
        end
        if (w_adv3) begin
            v3_d = w_s3_v;
            if (w_s3_v) d3_d = w_s3_d;
        end
    end

`ifdef S_BOX_INVERSE_GF_INV_EN
    always_comb begin
        v2b_d = v2b_q;
        d2b_d = d2b_q;
        if (w_adv2b) begin
            v2b_d = v2_q;
            if (v2_q) d2b_d = w_inv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2b_q <= 1'b0;
            d2b_q <= 8'h00;
        end else begin
            v2b_q <= v2b_d;
            d2b_q <= d2b_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            d1_q <= 8'h00;
            d2_q <= 8'h00;
            d3_q <= 8'h00;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
        end
    end

    assign odata  = d3_q;
    assign ovalid = v3_q;

endmodule
`default_nettype wire

// File: tb/tb_s_box_inverse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_s_box_inverse                                                         |
// | Randomized scoreboard bench for s_box_inverse (honours GF_INV_EN macro). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_s_box_inverse;

`ifdef S_BOX_INVERSE_GF_INV_EN
    localparam int         LAT        = 4;
    localparam logic [7:0] C_EXP_27   = 8'h3D;
    localparam logic [7:0] C_EXP_00   = 8'h52;
`else
    localparam int         LAT        = 3;
    localparam logic [7:0] C_EXP_27   = 8'hBB;
    localparam logic [7:0] C_EXP_00   = 8'h05;
`endif

    logic       clk, rst;
    logic [7:0] idata, odata;
    logic       ivalid, iready, ovalid, oready;

    s_box_inverse dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ref_tab [256];
    logic [7:0] stim_q [$];
    logic [7:0] exp_q [$];
    int         cyc = 0, acc_cnt = 0, out_cnt = 0;
    int         last_out_cyc = 0, prev_out_cyc = 0;
    logic [7:0] last_out = 8'h00, hold_data = 8'h00;
    bit         hold_prev = 1'b0, bub_mode = 1'b0;
    logic [7:0] hist = 8'h00;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11B;
        end
        return p;
    endfunction

    function automatic int rot(input int x, input int k);
        return ((x << k) | (x >> (8 - k))) & 255;
    endfunction

    function automatic int fwd_aff(input int x);
        return x ^ rot(x, 1) ^ rot(x, 2) ^ rot(x, 3) ^ rot(x, 4) ^ 'h63;
    endfunction

    // Expected output = preimage of the forward transform of the enabled build.
    task automatic build_ref();
        int ginv [256];
        for (int x = 0; x < 256; x++) begin
            ginv[x] = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(x, y) == 1) ginv[x] = y;
        end
        for (int x = 0; x < 256; x++) begin
`ifdef S_BOX_INVERSE_GF_INV_EN
            ref_tab[fwd_aff(ginv[x])] = 8'(x);
`else
            ref_tab[fwd_aff(x)] = 8'(x);
`endif
        end
    endtask

    task automatic step(input bit iv_en, input bit ordy);
        bit acc;
        @(negedge clk);
        ivalid = iv_en && (stim_q.size() > 0);
        idata  = ivalid ? stim_q[0] : 8'($urandom);
        oready = ordy;
        #1;
        if (hold_prev) check("hold", {7'b0, ovalid, odata}, {7'b0, 1'b1, hold_data});
        if (bub_mode) check("bubble_pattern", 16'(ovalid), 16'(hist[LAT-1]));
        if (ovalid && exp_q.size() == 0) check("spurious_ovalid", 16'(ovalid), 16'd0);
        else if (ovalid && oready) begin
            check("data", 16'(odata), 16'(exp_q.pop_front()));
            last_out     = odata;
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
            out_cnt++;
        end
        hold_prev = ovalid && !oready;
        hold_data = odata;
        acc = ivalid && iready;
        if (acc) begin
            exp_q.push_back(ref_tab[stim_q[0]]);
            void'(stim_q.pop_front());
            acc_cnt++;
        end
        hist = {hist[6:0], acc};
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || stim_q.size() > 0) && n < 3000) begin
            step(1'b1, 1'b1);
            n++;
        end
        check("drain_timeout", 16'(exp_q.size() + stim_q.size()), 16'd0);
    endtask

    initial begin
        int a0, o0, c0;
        rst = 1'b0; ivalid = 1'b0; idata = 8'h00; oready = 1'b0;
        build_ref();
        #1 rst = 1'b1;
        #1;
        check("rst_ovalid", 16'(ovalid), 16'd0);
        check("rst_odata",  16'(odata),  16'd0);
        check("rst_iready", 16'(iready), 16'd0);
        @(negedge clk); #3 rst = 1'b0;

        // Single byte latency and value
        stim_q.push_back(8'h27);
        c0 = cyc;
        a0 = acc_cnt;
        step(1'b1, 1'b1);
        check("first_accept", 16'(acc_cnt - a0), 16'd1);
        drain();
        check("latency", 16'(last_out_cyc - c0), 16'(LAT));
        check("single_value", 16'(last_out), 16'(C_EXP_27));

        // Corner values back-to-back
        stim_q.push_back(8'h63);
        stim_q.push_back(8'h7C);
        drain();
        check("corner_consecutive", 16'(last_out_cyc - prev_out_cyc), 16'd1);
        check("corner_last", 16'(last_out), 16'h01);

        // Backpressure fill and release
        stim_q.push_back(8'h27); stim_q.push_back(8'h63);
        stim_q.push_back(8'h7C); stim_q.push_back(8'h00);
        a0 = acc_cnt;
        o0 = out_cnt;
        repeat (8) step(1'b1, 1'b0);
        check("bp_accepts", 16'(acc_cnt - a0), 16'(LAT));
        check("bp_iready", 16'(iready), 16'd0);
        check("bp_held_data", 16'(odata), 16'(C_EXP_27));
        drain();
        check("bp_out_count", 16'(out_cnt - o0), 16'd4);
        check("bp_last", 16'(last_out), 16'(C_EXP_00));

        // Bubbles: ovalid mirrors accept pattern delayed by latency
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
        hist = 8'h00;
        bub_mode = 1'b1;
        for (int i = 0; i < 24; i++) step(i[0] == 1'b0, 1'b1);
        bub_mode = 1'b0;
        drain();

        // Async reset with two bytes in flight
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        @(negedge clk); #3 rst = 1'b1;
        #1;
        check("midrst_ovalid", 16'(ovalid), 16'd0);
        check("midrst_odata",  16'(odata),  16'd0);
        check("midrst_iready", 16'(iready), 16'd0);
        exp_q.delete();
        stim_q.delete();
        hold_prev = 1'b0;
        ivalid = 1'b0;
        @(negedge clk); #3 rst = 1'b0;
        o0 = out_cnt;
        repeat (8) step(1'b0, 1'b1);
        check("midrst_no_stale", 16'(out_cnt - o0), 16'd0);

        // Exhaustive with random handshakes
        for (int i = 0; i < 256; i++) stim_q.push_back(8'(i));
        o0 = out_cnt;
        c0 = 0;
        while ((exp_q.size() > 0 || stim_q.size() > 0) && c0 < 5000) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0);
            c0++;
        end
        check("exh_timeout", 16'(exp_q.size() + stim_q.size()), 16'd0);
        check("exh_count", 16'(out_cnt - o0), 16'd256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
